// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port sync RAM between the IF and LS units.
// Latency: grant is combinational, and the response arrives 1 cycle after the grant edge.
// Backpressure: requests stall by withholding gnt; responses cannot be stalled.
module ram_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_err,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [31:0]      ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    output logic             ls_gnt,
    output logic             ls_rvalid,
    output logic [WIDTH-1:0] ls_rdata,
    output logic             ls_err,
    output logic [DEPTH-1:0] ram_addr,
    output logic             ram_wren,
    output logic [WIDTH-1:0] ram_wrdata,
    input  logic [WIDTH-1:0] ram_rddata
);

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

    logic             w_if_err;
    logic             w_ls_err;
    logic [DEPTH-1:0] w_if_idx;
    logic [DEPTH-1:0] w_ls_idx;
    logic             w_if_gnt;
    logic             w_ls_gnt;
    logic             w_if_rsp;
    logic             w_ls_rsp;

    port_e            r_last_grant;
    port_e            r_rsp_port;
    logic             r_rsp_vld;
    logic             r_rsp_err;

    // Misaligned or beyond the RAM's byte range.
    assign w_if_err = (if_addr[1:0] != 2'b00) | (|if_addr[31:DEPTH+2]);
    assign w_ls_err = (ls_addr[1:0] != 2'b00) | (|ls_addr[31:DEPTH+2]);
    assign w_if_idx = if_addr[DEPTH+1:2];
    assign w_ls_idx = ls_addr[DEPTH+1:2];

    always_comb begin
        w_if_gnt = 1'b0;
        w_ls_gnt = 1'b0;
        if (rst_n) begin
            if (if_req && ls_req) begin
                if (r_last_grant == PORT_LS) w_if_gnt = 1'b1;
                else                         w_ls_gnt = 1'b1;
            end else begin
                w_if_gnt = if_req;
                w_ls_gnt = ls_req;
            end
        end
    end

    assign if_gnt = w_if_gnt;
    assign ls_gnt = w_ls_gnt;

    always_comb begin
        ram_addr   = '0;
        ram_wren   = 1'b0;
        ram_wrdata = '0;
        if (w_if_gnt) begin
            ram_addr = w_if_idx;
        end else if (w_ls_gnt) begin
            ram_addr   = w_ls_idx;
            ram_wren   = ls_we & ~w_ls_err;
            ram_wrdata = ls_wdata;
        end
    end

    // Error grants still consume a slot and rotate priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= PORT_LS;
            r_rsp_port   <= PORT_IF;
            r_rsp_vld    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp_vld <= w_if_gnt | w_ls_gnt;
            r_rsp_err <= (w_if_gnt & w_if_err) | (w_ls_gnt & w_ls_err);
            if (w_if_gnt || w_ls_gnt) begin
                r_last_grant <= w_ls_gnt ? PORT_LS : PORT_IF;
                r_rsp_port   <= w_ls_gnt ? PORT_LS : PORT_IF;
            end
        end
    end

    assign w_if_rsp = r_rsp_vld & (r_rsp_port == PORT_IF);
    assign w_ls_rsp = r_rsp_vld & (r_rsp_port == PORT_LS);

    assign if_rvalid = w_if_rsp;
    assign if_err    = w_if_rsp & r_rsp_err;
    assign if_rdata  = (w_if_rsp && !r_rsp_err) ? ram_rddata : '0;
    assign ls_rvalid = w_ls_rsp;
    assign ls_err    = w_ls_rsp & r_rsp_err;
    assign ls_rdata  = (w_ls_rsp && !r_rsp_err) ? ram_rddata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a read-before-write RAM model attached.
module tb_ram_port_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_req;
    logic [31:0]      if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [WIDTH-1:0] if_rdata;
    logic             if_err;
    logic             ls_req;
    logic             ls_we;
    logic [31:0]      ls_addr;
    logic [WIDTH-1:0] ls_wdata;
    logic             ls_gnt;
    logic             ls_rvalid;
    logic [WIDTH-1:0] ls_rdata;
    logic             ls_err;
    logic [DEPTH-1:0] ram_addr;
    logic             ram_wren;
    logic [WIDTH-1:0] ram_wrdata;
    logic [WIDTH-1:0] ram_rddata = '0;

    logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];
    bit               mem_init;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wrdata(ram_wrdata),
        .ram_rddata(ram_rddata)
    );

    // Word i initially holds 0xA5000000 | i.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < (1 << DEPTH); i++) mem[i] <= 32'hA500_0000 | i;
            mem_init <= 1'b1;
        end else begin
            ram_rddata <= mem[ram_addr];
            if (ram_wren) mem[ram_addr] <= ram_wrdata;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h10; ls_wdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        check_val("rst_if_gnt", 32'(if_gnt), 0);
        check_val("rst_ls_gnt", 32'(ls_gnt), 0);
        check_val("rst_ram_wren", 32'(ram_wren), 0);
        check_val("rst_ram_addr", 32'(ram_addr), 0);
        check_val("rst_ram_wrdata", ram_wrdata, 0);
        check_val("rst_if_rvalid", 32'(if_rvalid), 0);
        check_val("rst_ls_rvalid", 32'(ls_rvalid), 0);
        check_val("rst_ls_rdata", ls_rdata, 0);
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; rst_n = 1'b1;

        // Reset while an LS read is in flight: response is dropped.
        step();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10;
        @(negedge clk);
        check_val("t1_ls_gnt", 32'(ls_gnt), 1);
        step();
        ls_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check_val("t1_ls_rvalid", 32'(ls_rvalid), 0);
        check_val("t1_ls_rdata", ls_rdata, 0);
        check_val("t1_ls_err", 32'(ls_err), 0);
        check_val("t1_if_rvalid", 32'(if_rvalid), 0);
        rst_n = 1'b1;

        // Write then read back through the other port.
        step();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h10; ls_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_val("t2_ls_gnt", 32'(ls_gnt), 1);
        check_val("t2_ram_wren", 32'(ram_wren), 1);
        check_val("t2_ram_addr", 32'(ram_addr), 4);
        check_val("t2_ram_wrdata", ram_wrdata, 32'hDEAD_BEEF);
        step();
        ls_req = 1'b0; ls_we = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        check_val("t2_ls_rvalid", 32'(ls_rvalid), 1);
        check_val("t2_ls_rdata_old", ls_rdata, 32'hA500_0004);
        check_val("t2_ls_err", 32'(ls_err), 0);
        check_val("t2_if_gnt", 32'(if_gnt), 1);
        check_val("t2_if_rvalid_early", 32'(if_rvalid), 0);
        step();
        if_req = 1'b0;
        @(negedge clk);
        check_val("t2_if_rvalid", 32'(if_rvalid), 1);
        check_val("t2_if_rdata", if_rdata, 32'hDEAD_BEEF);
        check_val("t2_ls_rvalid_idle", 32'(ls_rvalid), 0);

        // Continuous conflict from reset: IF, LS, IF, LS.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h20; ls_req = 1'b1; ls_addr = 32'h24;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val($sformatf("t3_if_gnt_%0d", k), 32'(if_gnt), (k % 2 == 0) ? 1 : 0);
            check_val($sformatf("t3_ls_gnt_%0d", k), 32'(ls_gnt), (k % 2 == 1) ? 1 : 0);
            if (k > 0) begin
                check_val($sformatf("t3_if_rvalid_%0d", k), 32'(if_rvalid), ((k - 1) % 2 == 0) ? 1 : 0);
                check_val($sformatf("t3_ls_rvalid_%0d", k), 32'(ls_rvalid), ((k - 1) % 2 == 1) ? 1 : 0);
                check_val($sformatf("t3_if_rdata_%0d", k), if_rdata, ((k - 1) % 2 == 0) ? 32'hA500_0008 : 0);
                check_val($sformatf("t3_ls_rdata_%0d", k), ls_rdata, ((k - 1) % 2 == 1) ? 32'hA500_0009 : 0);
            end
            step();
        end
        if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);
        check_val("t3_ls_rvalid_last", 32'(ls_rvalid), 1);
        check_val("t3_ls_rdata_last", ls_rdata, 32'hA500_0009);
        check_val("t3_if_rvalid_last", 32'(if_rvalid), 0);

        // Misaligned write and out-of-range read.
        step();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h12; ls_wdata = 32'h1234_5678;
        @(negedge clk);
        check_val("t4_ls_gnt", 32'(ls_gnt), 1);
        check_val("t4_ls_wren", 32'(ram_wren), 0);
        check_val("t4_ls_ram_addr", 32'(ram_addr), 4);
        step();
        ls_req = 1'b0; ls_we = 1'b0; if_req = 1'b1; if_addr = 32'h1000;
        @(negedge clk);
        check_val("t4_ls_rvalid", 32'(ls_rvalid), 1);
        check_val("t4_ls_err", 32'(ls_err), 1);
        check_val("t4_ls_rdata", ls_rdata, 0);
        check_val("t4_if_gnt", 32'(if_gnt), 1);
        check_val("t4_if_wren", 32'(ram_wren), 0);
        check_val("t4_if_ram_addr", 32'(ram_addr), 0);
        step();
        if_addr = 32'h10;
        @(negedge clk);
        check_val("t4_if_rvalid", 32'(if_rvalid), 1);
        check_val("t4_if_err", 32'(if_err), 1);
        check_val("t4_if_rdata", if_rdata, 0);
        step();
        if_req = 1'b0;
        @(negedge clk);
        check_val("t4_readback", if_rdata, 32'hDEAD_BEEF);
        check_val("t4_readback_err", 32'(if_err), 0);
        check_val("t4_mem_unchanged", mem[4], 32'hDEAD_BEEF);

        // IF-only stream, one access per cycle.
        for (int i = 0; i < 4; i++) begin
            step();
            if_req = 1'b1; if_addr = 32'(4 * i);
            @(negedge clk);
            check_val($sformatf("t5_if_gnt_%0d", i), 32'(if_gnt), 1);
            check_val($sformatf("t5_ram_addr_%0d", i), 32'(ram_addr), i);
            if (i > 0) begin
                check_val($sformatf("t5_if_rvalid_%0d", i), 32'(if_rvalid), 1);
                check_val($sformatf("t5_if_rdata_%0d", i), if_rdata, 32'hA500_0000 | (i - 1));
            end
        end
        step();
        if_req = 1'b0;
        @(negedge clk);
        check_val("t5_if_rvalid_4", 32'(if_rvalid), 1);
        check_val("t5_if_rdata_4", if_rdata, 32'hA500_0003);
        step();
        @(negedge clk);
        check_val("t5_idle_rvalid", 32'(if_rvalid), 0);

        // Highest legal address.
        step();
        if_req = 1'b1; if_addr = 32'hFFC;
        @(negedge clk);
        check_val("t6_if_gnt", 32'(if_gnt), 1);
        check_val("t6_ram_addr", 32'(ram_addr), 1023);
        step();
        if_req = 1'b0;
        @(negedge clk);
        check_val("t6_if_rvalid", 32'(if_rvalid), 1);
        check_val("t6_if_err", 32'(if_err), 0);
        check_val("t6_if_rdata", if_rdata, 32'hA500_03FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
